accel_controller: RTL and testbench
===================================

Name: accel_controller

Overview:
Top-level sequencing FSM of the accelerator tile. On a start request it runs four phases: weight load, input load, compute, output store. Each memory phase is driven through the address generation unit (AGU), with AGU addresses forwarded to the banked scratchpad. The compute phase is a start/done handshake with the compute engine; status is reported through ctrl_resp.

Parameters:
- BEAT_SHIFT, default 2: each AGU beat covers 2^BEAT_SHIFT bytes (one bank row); phase beat count = ceil(size / 2^BEAT_SHIFT).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ctrl_req  in  ctrl_req_t  {start, accel_type, config_data[15:0]}
- ctrl_resp  out  ctrl_resp_t  {state (state_e), busy, done, error[7:0]}
- mem_req  out  mem_req_t  {addr[ADDR_WIDTH-1:0], wdata[7:0], re, we, bank_sel[4:0]}
- mem_resp  in  mem_resp_t  {data[7:0], valid, ready}
- agu_start  out  1  one-cycle AGU launch pulse
- agu_pattern  out  access_pattern_e  AGU pattern
- agu_base_addr  out  ADDR_WIDTH  AGU base
- agu_length  out  16  AGU beat count
- agu_done  in  1  AGU finished; level, cleared by AGU on the cycle after agu_start
- agu_addr  in  ADDR_WIDTH  generated address
- agu_addr_valid  in  1  address valid
- agu_addr_ready  out  1  address accepted
- compute_start  out  1  one-cycle compute launch pulse
- compute_config  out  16  latched config_data
- compute_done  in  1  level; may be stale-high until the cycle after compute_start
- compute_error  in  8  nonzero means compute fault
- weight_base_addr, input_base_addr, output_base_addr  in  ADDR_WIDTH  region bases
- weight_size, input_size, output_size  in  16  region sizes in bytes
- weight_bank, input_bank, output_bank  in  5  bank select per region

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 (done, busy, error, agu_start, compute_start, re, we, bank_sel, addr, wdata, compute_config). Reset mid-operation aborts immediately to IDLE.
- States: IDLE, LOAD_WEIGHTS, LOAD_INPUT, COMPUTE, STORE_OUTPUT, DONE. ctrl_resp.state is the registered current state.
- IDLE or DONE with start=1: latch accel_type and config_data (compute_config=config_data), clear done/error, go to LOAD_WEIGHTS. Start in any other state is ignored.
- Memory phase, on entry: pulse agu_start for the first cycle with base, length and pattern set. agu_done is ignored on that cycle. Phase ends on the first cycle after it with agu_done=1.
- Beat count 0 (size 0): no agu_start; move to the next state after one cycle.
- Phase settings:
  - LOAD_WEIGHTS: weight_base_addr, SEQUENTIAL pattern, weight_bank.
  - LOAD_INPUT: input_base_addr; SLIDING_2D for ACCEL_CNN, SEQUENTIAL otherwise; input_bank.
  - STORE_OUTPUT: output_base_addr, SEQUENTIAL pattern, output_bank.
- While in a memory state:
  - bank_sel = that phase's bank, combinationally, for the whole state.
  - agu_addr_ready = mem_resp.ready.
  - addr = agu_addr.
  - re = agu_addr_valid in load states; we = agu_addr_valid in STORE_OUTPUT.
- Outside memory states: re=we=0, agu_addr_ready=0.
- wdata = last mem_resp.data captured on mem_resp.valid. Read data is otherwise consumed by the datapath, not the controller.
- COMPUTE: pulse compute_start on the entry cycle; compute_done is ignored that cycle. On a later compute_done=1, latch compute_error into ctrl_resp.error. error==0 goes to STORE_OUTPUT; nonzero goes directly to DONE.
- DONE: done=1, held until the next start.
- busy=1 in every state except IDLE and DONE.

Decomposition:
- accel_pkg holds:
  - ADDR_WIDTH=16.
  - accel_type_e: ACCEL_MLP, ACCEL_CNN, ACCEL_RNN.
  - access_pattern_e: SEQUENTIAL, STRIDED, SLIDING_2D.
  - state_e: the six states above.
  - Bank constants: BANK_WEIGHT_0..7 = 0..7, BANK_INPUT_0..3 = 8..11, BANK_OUTPUT_0..1 = 12..13.
  - Structs ctrl_req_t, ctrl_resp_t, mem_req_t, mem_resp_t.
- The FSM plus a small phase-mux is natural in one module; no sub-module is required.

Test Plan:
- Reset, then MLP start with weights 0x1000/100, input 0x2000/64, output 0x3000/10. Required: states IDLE→LOAD_WEIGHTS→LOAD_INPUT→COMPUTE→STORE_OUTPUT→DONE; agu_length 25, 16, 3; done within 100 cycles.
- CNN with config_data=0x3100. Required: agu_pattern=SLIDING_2D during LOAD_INPUT; compute_config=0x3100; done reached.
- RNN with config_data=0x0010. Required: SEQUENTIAL input pattern; completes with done=1, error=0.
- Bank routing with weight_bank=BANK_WEIGHT_5, input_bank=BANK_INPUT_1, output_bank=BANK_OUTPUT_1. Required: one cycle into LOAD_WEIGHTS, bank_sel=5; one cycle into LOAD_INPUT, bank_sel=9; in STORE_OUTPUT, bank_sel=13 with we pulses.
- Stale done handling: agu_done/compute_done held high from the previous run when a new start arrives. Required: no phase skipped; compute_error=0x04 gives error=0x04, no STORE_OUTPUT, DONE.
- weight_size=0. Required: no agu_start in LOAD_WEIGHTS; next state after one cycle. Reset asserted mid-LOAD_INPUT gives IDLE and all outputs 0 immediately.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types, bank map and helpers for the accelerator tile controller.
package accel_pkg;

    localparam int unsigned ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        ACCEL_MLP = 2'd0,
        ACCEL_CNN = 2'd1,
        ACCEL_RNN = 2'd2
    } accel_type_e;

    typedef enum logic [1:0] {
        SEQUENTIAL = 2'd0,
        STRIDED    = 2'd1,
        SLIDING_2D = 2'd2
    } access_pattern_e;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        LOAD_WEIGHTS = 3'd1,
        LOAD_INPUT   = 3'd2,
        COMPUTE      = 3'd3,
        STORE_OUTPUT = 3'd4,
        DONE         = 3'd5
    } state_e;

    localparam logic [4:0] BANK_WEIGHT_0 = 5'd0;
    localparam logic [4:0] BANK_WEIGHT_1 = 5'd1;
    localparam logic [4:0] BANK_WEIGHT_2 = 5'd2;
    localparam logic [4:0] BANK_WEIGHT_3 = 5'd3;
    localparam logic [4:0] BANK_WEIGHT_4 = 5'd4;
    localparam logic [4:0] BANK_WEIGHT_5 = 5'd5;
    localparam logic [4:0] BANK_WEIGHT_6 = 5'd6;
    localparam logic [4:0] BANK_WEIGHT_7 = 5'd7;
    localparam logic [4:0] BANK_INPUT_0  = 5'd8;
    localparam logic [4:0] BANK_INPUT_1  = 5'd9;
    localparam logic [4:0] BANK_INPUT_2  = 5'd10;
    localparam logic [4:0] BANK_INPUT_3  = 5'd11;
    localparam logic [4:0] BANK_OUTPUT_0 = 5'd12;
    localparam logic [4:0] BANK_OUTPUT_1 = 5'd13;

    typedef struct packed {
        logic        start;
        accel_type_e accel_type;
        logic [15:0] config_data;
    } ctrl_req_t;

    typedef struct packed {
        state_e      state;
        logic        busy;
        logic        done;
        logic [7:0]  error;
    } ctrl_resp_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            wdata;
        logic                  re;
        logic                  we;
        logic [4:0]            bank_sel;
    } mem_req_t;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
    } mem_resp_t;

    // Number of bank-row beats needed to cover 'size' bytes (rounded up).
    function automatic logic [15:0] beat_count(input logic [15:0] size, input int unsigned shift);
        logic [16:0] w_round;
        w_round = {1'b0, size} + ((17'd1 << shift) - 17'd1);
        return 16'(w_round >> shift);
    endfunction

endpackage

// File: rtl/accel_controller.sv
// Tile sequencer: weight load, input load, compute, output store.
module accel_controller
    import accel_pkg::*;
#(
    parameter int unsigned BEAT_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  ctrl_req_t             ctrl_req,
    output ctrl_resp_t            ctrl_resp,
    output mem_req_t              mem_req,
    input  mem_resp_t             mem_resp,
    output logic                  agu_start,
    output access_pattern_e       agu_pattern,
    output logic [ADDR_WIDTH-1:0] agu_base_addr,
    output logic [15:0]           agu_length,
    input  logic                  agu_done,
    input  logic [ADDR_WIDTH-1:0] agu_addr,
    input  logic                  agu_addr_valid,
    output logic                  agu_addr_ready,
    output logic                  compute_start,
    output logic [15:0]           compute_config,
    input  logic                  compute_done,
    input  logic [7:0]            compute_error,
    input  logic [ADDR_WIDTH-1:0] weight_base_addr,
    input  logic [ADDR_WIDTH-1:0] input_base_addr,
    input  logic [ADDR_WIDTH-1:0] output_base_addr,
    input  logic [15:0]           weight_size,
    input  logic [15:0]           input_size,
    input  logic [15:0]           output_size,
    input  logic [4:0]            weight_bank,
    input  logic [4:0]            input_bank,
    input  logic [4:0]            output_bank
);

    state_e                r_state;
    state_e                w_next_state;
    logic                  r_first;
    accel_type_e           r_accel_type;
    logic [15:0]           r_config;
    logic [7:0]            r_error;
    logic [7:0]            r_wdata;

    logic                  w_mem_phase;
    logic                  w_start_accept;
    logic                  w_compute_finish;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [15:0]           w_size;
    logic [15:0]           w_beats;
    logic [4:0]            w_bank;
    access_pattern_e       w_pattern;
    state_e                w_phase_next;

    // Select the settings of the memory phase the FSM is currently in.
    always_comb begin
        w_mem_phase  = 1'b0;
        w_base       = '0;
        w_size       = '0;
        w_bank       = '0;
        w_pattern    = SEQUENTIAL;
        w_phase_next = IDLE;
        case (r_state)
            LOAD_WEIGHTS: begin
                w_mem_phase  = 1'b1;
                w_base       = weight_base_addr;
                w_size       = weight_size;
                w_bank       = weight_bank;
                w_phase_next = LOAD_INPUT;
            end
            LOAD_INPUT: begin
                w_mem_phase  = 1'b1;
                w_base       = input_base_addr;
                w_size       = input_size;
                w_bank       = input_bank;
                w_pattern    = (r_accel_type == ACCEL_CNN) ? SLIDING_2D : SEQUENTIAL;
                w_phase_next = COMPUTE;
            end
            STORE_OUTPUT: begin
                w_mem_phase  = 1'b1;
                w_base       = output_base_addr;
                w_size       = output_size;
                w_bank       = output_bank;
                w_phase_next = DONE;
            end
            default: ;
        endcase
    end

    assign w_beats = beat_count(w_size, BEAT_SHIFT);

    // Next-state logic and launch pulses; done inputs are ignored on the entry
    // cycle because the engines only drop a stale done after seeing the launch.
    always_comb begin
        w_next_state     = r_state;
        w_start_accept   = 1'b0;
        w_compute_finish = 1'b0;
        agu_start        = 1'b0;
        compute_start    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (ctrl_req.start) begin
                    w_start_accept = 1'b1;
                    w_next_state   = LOAD_WEIGHTS;
                end
            end
            LOAD_WEIGHTS, LOAD_INPUT, STORE_OUTPUT: begin
                if (r_first) begin
                    if (w_beats == '0) begin
                        w_next_state = w_phase_next;
                    end else begin
                        agu_start = 1'b1;
                    end
                end else if (agu_done) begin
                    w_next_state = w_phase_next;
                end
            end
            COMPUTE: begin
                if (r_first) begin
                    compute_start = 1'b1;
                end else if (compute_done) begin
                    w_compute_finish = 1'b1;
                    w_next_state     = (compute_error == '0) ? STORE_OUTPUT : DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register, entry flag and per-run latched context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_first      <= 1'b0;
            r_accel_type <= ACCEL_MLP;
            r_config     <= '0;
            r_error      <= '0;
        end else begin
            r_state <= w_next_state;
            r_first <= (w_next_state != r_state);
            if (w_start_accept) begin
                r_accel_type <= ctrl_req.accel_type;
                r_config     <= ctrl_req.config_data;
                r_error      <= '0;
            end else if (w_compute_finish) begin
                r_error <= compute_error;
            end
        end
    end

    // Capture the most recent valid read beat for the write-data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdata <= '0;
        end else if (mem_resp.valid) begin
            r_wdata <= mem_resp.data;
        end
    end

    // Route AGU addresses to the scratchpad while a memory phase is active.
    always_comb begin
        mem_req       = '0;
        mem_req.wdata = r_wdata;
        if (w_mem_phase) begin
            mem_req.addr     = agu_addr;
            mem_req.bank_sel = w_bank;
            mem_req.re       = agu_addr_valid && (r_state != STORE_OUTPUT);
            mem_req.we       = agu_addr_valid && (r_state == STORE_OUTPUT);
        end
    end

    assign agu_addr_ready  = w_mem_phase & mem_resp.ready;
    assign agu_base_addr   = w_base;
    assign agu_length      = w_beats;
    assign agu_pattern     = w_pattern;
    assign compute_config  = r_config;

    assign ctrl_resp.state = r_state;
    assign ctrl_resp.busy  = (r_state != IDLE) && (r_state != DONE);
    assign ctrl_resp.done  = (r_state == DONE);
    assign ctrl_resp.error = r_error;

endmodule

// File: tb/tb_accel_controller.sv
// Self-checking bench for accel_controller with simple AGU/compute responders.
module tb_accel_controller;
    import accel_pkg::*;

    localparam int BEAT_BYTES = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    ctrl_req_t       ctrl_req;
    ctrl_resp_t      ctrl_resp;
    mem_req_t        mem_req;
    mem_resp_t       mem_resp;
    logic            agu_start;
    access_pattern_e agu_pattern;
    logic [15:0]     agu_base_addr, agu_length;
    logic            agu_done = 1'b0;
    logic [15:0]     agu_addr;
    logic            agu_addr_valid, agu_addr_ready;
    logic            compute_start;
    logic [15:0]     compute_config;
    logic            compute_done = 1'b0;
    logic [7:0]      compute_error;
    logic [15:0]     w_base, i_base, o_base, w_size, i_size, o_size;
    logic [4:0]      w_bank, i_bank, o_bank;

    accel_controller #(.BEAT_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_req(ctrl_req), .ctrl_resp(ctrl_resp),
        .mem_req(mem_req), .mem_resp(mem_resp),
        .agu_start(agu_start), .agu_pattern(agu_pattern), .agu_base_addr(agu_base_addr),
        .agu_length(agu_length), .agu_done(agu_done), .agu_addr(agu_addr),
        .agu_addr_valid(agu_addr_valid), .agu_addr_ready(agu_addr_ready),
        .compute_start(compute_start), .compute_config(compute_config),
        .compute_done(compute_done), .compute_error(compute_error),
        .weight_base_addr(w_base), .input_base_addr(i_base), .output_base_addr(o_base),
        .weight_size(w_size), .input_size(i_size), .output_size(o_size),
        .weight_bank(w_bank), .input_bank(i_bank), .output_bank(o_bank)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- responders ----------------
    int unsigned a_cnt = 0;
    logic [15:0] a_base = '0;
    int unsigned c_cnt = 0;
    logic [7:0]  cerr = '0;
    logic        m_ready = 1'b1;

    always @(posedge clk) begin
        if (agu_start) begin
            agu_done <= 1'b0;
            a_cnt    <= 3;
            a_base   <= agu_base_addr;
        end else if (a_cnt != 0) begin
            a_cnt <= a_cnt - 1;
            if (a_cnt == 1) agu_done <= 1'b1;
        end
    end
    assign agu_addr_valid = (a_cnt != 0);
    assign agu_addr       = a_base + 16'(a_cnt);

    always @(posedge clk) begin
        if (compute_start) begin
            compute_done <= 1'b0;
            c_cnt        <= 3;
        end else if (c_cnt != 0) begin
            c_cnt <= c_cnt - 1;
            if (c_cnt == 1) compute_done <= 1'b1;
        end
    end
    assign compute_error = cerr;

    initial begin
        int unsigned cyc = 0;
        mem_resp = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            mem_resp.valid = cyc[0];
            mem_resp.data  = 8'(cyc * 37 + 5);
            mem_resp.ready = m_ready;
        end
    end

    // ---------------- model ----------------
    typedef struct {
        state_e          st;
        logic [15:0]     base;
        logic [15:0]     len;
        access_pattern_e pat;
    } launch_t;

    accel_type_e run_type = ACCEL_MLP;
    logic [7:0]  run_err = '0;
    logic [15:0] exp_cfg = '0;
    logic [7:0]  exp_wdata = '0;
    state_e      prev_st = IDLE;
    state_e      trace[$];
    launch_t     launches[$];
    int          state_cycles[6];
    int          seen_bank[6];
    int          we_count = 0;

    function automatic int beats(input int size);
        return (size + BEAT_BYTES - 1) / BEAT_BYTES;
    endfunction

    function automatic bit is_mem(input state_e s);
        return s == LOAD_WEIGHTS || s == LOAD_INPUT || s == STORE_OUTPUT;
    endfunction

    function automatic int phase_size(input state_e s);
        case (s)
            LOAD_WEIGHTS: return int'(w_size);
            LOAD_INPUT:   return int'(i_size);
            STORE_OUTPUT: return int'(o_size);
            default:      return 0;
        endcase
    endfunction

    function automatic logic [15:0] phase_base(input state_e s);
        case (s)
            LOAD_WEIGHTS: return w_base;
            LOAD_INPUT:   return i_base;
            STORE_OUTPUT: return o_base;
            default:      return 16'h0;
        endcase
    endfunction

    function automatic logic [4:0] phase_bank(input state_e s);
        case (s)
            LOAD_WEIGHTS: return w_bank;
            LOAD_INPUT:   return i_bank;
            STORE_OUTPUT: return o_bank;
            default:      return 5'd0;
        endcase
    endfunction

    function automatic access_pattern_e phase_pat(input state_e s);
        if (s == LOAD_INPUT && run_type == ACCEL_CNN) return SLIDING_2D;
        return SEQUENTIAL;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_wdata = '0;
        else if (mem_resp.valid) exp_wdata = mem_resp.data;
    end

    // Per-cycle comparison against the behavioural rules.
    always @(negedge clk) begin
        state_e st;
        bit entry, mem, exp_launch;
        if (!rst_n) begin
            prev_st = IDLE;
        end else begin
            st    = ctrl_resp.state;
            entry = (st != prev_st);
            mem   = is_mem(st);
            if (entry) begin
                trace.push_back(st);
                seen_bank[int'(st)] = int'(mem_req.bank_sel);
            end
            state_cycles[int'(st)]++;
            if (mem_req.we) we_count++;
            chk("busy", ctrl_resp.busy, (st != IDLE && st != DONE));
            chk("done", ctrl_resp.done, st == DONE);
            chk("error", ctrl_resp.error, (st == DONE) ? run_err : 8'h00);
            chk("compute_config", compute_config, exp_cfg);
            chk("wdata", mem_req.wdata, exp_wdata);
            chk("bank_sel", mem_req.bank_sel, phase_bank(st));
            chk("addr", mem_req.addr, mem ? agu_addr : 16'h0);
            chk("re", mem_req.re, mem && st != STORE_OUTPUT && agu_addr_valid);
            chk("we", mem_req.we, st == STORE_OUTPUT && agu_addr_valid);
            chk("addr_ready", agu_addr_ready, mem && mem_resp.ready);
            exp_launch = mem && entry && beats(phase_size(st)) > 0;
            chk("agu_start", agu_start, exp_launch);
            chk("compute_start", compute_start, st == COMPUTE && entry);
            if (agu_start) begin
                chk("agu_base", agu_base_addr, phase_base(st));
                chk("agu_length", agu_length, beats(phase_size(st)));
                chk("agu_pattern", int'(agu_pattern), int'(phase_pat(st)));
                launches.push_back('{st, agu_base_addr, agu_length, agu_pattern});
            end
            prev_st = st;
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, int'(ctrl_resp.state), int'(IDLE));
        chk({tag, "_busy"}, ctrl_resp.busy, 0);
        chk({tag, "_done"}, ctrl_resp.done, 0);
        chk({tag, "_error"}, ctrl_resp.error, 0);
        chk({tag, "_agu_start"}, agu_start, 0);
        chk({tag, "_compute_start"}, compute_start, 0);
        chk({tag, "_re"}, mem_req.re, 0);
        chk({tag, "_we"}, mem_req.we, 0);
        chk({tag, "_bank_sel"}, mem_req.bank_sel, 0);
        chk({tag, "_addr"}, mem_req.addr, 0);
        chk({tag, "_wdata"}, mem_req.wdata, 0);
        chk({tag, "_compute_config"}, compute_config, 0);
        chk({tag, "_addr_ready"}, agu_addr_ready, 0);
    endtask

    task automatic do_run(input accel_type_e t, input logic [15:0] cfg,
                          input logic [7:0] err, input bit mid_start);
        bit reached = 0;
        bit pulsed = 0;
        state_e  exp_tr[$];
        launch_t exp_l[$];
        trace.delete();
        launches.delete();
        for (int i = 0; i < 6; i++) begin
            state_cycles[i] = 0;
            seen_bank[i] = -1;
        end
        we_count = 0;
        run_type = t;
        cerr     = err;
        @(posedge clk); #1;
        ctrl_req.start       = 1'b1;
        ctrl_req.accel_type  = t;
        ctrl_req.config_data = cfg;
        @(posedge clk); #1;
        ctrl_req.start = 1'b0;
        run_err = err;
        exp_cfg = cfg;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ctrl_req.start = 1'b0;
            if (ctrl_resp.state == DONE) begin
                reached = 1;
                break;
            end
            if (mid_start && !pulsed && ctrl_resp.state == LOAD_INPUT) begin
                ctrl_req.start = 1'b1;
                pulsed = 1;
            end
        end
        chk("reach_done", reached, 1);
        repeat (2) @(negedge clk);

        exp_tr = '{LOAD_WEIGHTS, LOAD_INPUT, COMPUTE};
        if (err == 8'h00) exp_tr.push_back(STORE_OUTPUT);
        exp_tr.push_back(DONE);
        chk("trace_len", trace.size(), exp_tr.size());
        for (int i = 0; i < exp_tr.size() && i < trace.size(); i++)
            chk("trace_state", int'(trace[i]), int'(exp_tr[i]));

        if (beats(int'(w_size)) > 0)
            exp_l.push_back('{LOAD_WEIGHTS, w_base, 16'(beats(int'(w_size))), SEQUENTIAL});
        if (beats(int'(i_size)) > 0)
            exp_l.push_back('{LOAD_INPUT, i_base, 16'(beats(int'(i_size))),
                              (t == ACCEL_CNN) ? SLIDING_2D : SEQUENTIAL});
        if (err == 8'h00 && beats(int'(o_size)) > 0)
            exp_l.push_back('{STORE_OUTPUT, o_base, 16'(beats(int'(o_size))), SEQUENTIAL});
        chk("launch_count", launches.size(), exp_l.size());
        for (int i = 0; i < exp_l.size() && i < launches.size(); i++) begin
            chk("launch_state", int'(launches[i].st), int'(exp_l[i].st));
            chk("launch_len", launches[i].len, exp_l[i].len);
        end
    endtask

    function automatic int launch_len(input int k);
        return (k < launches.size()) ? int'(launches[k].len) : -1;
    endfunction

    function automatic int launch_pat(input int k);
        return (k < launches.size()) ? int'(launches[k].pat) : -1;
    endfunction

    initial begin
        bit reached;
        ctrl_req = '0;
        w_base = 16'h1000; w_size = 16'd100; w_bank = BANK_WEIGHT_0;
        i_base = 16'h2000; i_size = 16'd64;  i_bank = BANK_INPUT_0;
        o_base = 16'h3000; o_size = 16'd10;  o_bank = BANK_OUTPUT_0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // MLP baseline
        do_run(ACCEL_MLP, 16'h0001, 8'h00, 1'b0);
        chk("mlp_len_w", launch_len(0), 25);
        chk("mlp_len_i", launch_len(1), 16);
        chk("mlp_len_o", launch_len(2), 3);

        // CNN: sliding-window input pattern
        do_run(ACCEL_CNN, 16'h3100, 8'h00, 1'b0);
        chk("cnn_pat_i", launch_pat(1), int'(SLIDING_2D));
        chk("cnn_config", compute_config, 16'h3100);
        chk("cnn_done", ctrl_resp.done, 1);

        // RNN with a start pulse during LOAD_INPUT that must be ignored
        do_run(ACCEL_RNN, 16'h0010, 8'h00, 1'b1);
        chk("rnn_pat_i", launch_pat(1), int'(SEQUENTIAL));
        chk("rnn_done", ctrl_resp.done, 1);
        chk("rnn_error", ctrl_resp.error, 8'h00);

        // Bank routing
        w_bank = BANK_WEIGHT_5; i_bank = BANK_INPUT_1; o_bank = BANK_OUTPUT_1;
        do_run(ACCEL_MLP, 16'h0002, 8'h00, 1'b0);
        chk("bank_w", seen_bank[int'(LOAD_WEIGHTS)], 5);
        chk("bank_i", seen_bank[int'(LOAD_INPUT)], 9);
        chk("bank_o", seen_bank[int'(STORE_OUTPUT)], 13);
        chk("store_we_seen", we_count > 0, 1);

        // Stale done levels from the previous run plus a compute fault
        do_run(ACCEL_MLP, 16'h0003, 8'h04, 1'b0);
        chk("fault_error", ctrl_resp.error, 8'h04);
        chk("fault_no_store", state_cycles[int'(STORE_OUTPUT)], 0);
        chk("fault_done", ctrl_resp.done, 1);

        // Zero-size weight region
        w_size = 16'd0;
        do_run(ACCEL_MLP, 16'h0004, 8'h00, 1'b0);
        chk("zero_w_cycles", state_cycles[int'(LOAD_WEIGHTS)], 1);
        chk("zero_first_launch", (launches.size() > 0) ? int'(launches[0].st) : -1, int'(LOAD_INPUT));
        chk("zero_launches", launches.size(), 2);

        // Reset in the middle of LOAD_INPUT
        w_size = 16'd100;
        m_ready = 1'b1;
        @(posedge clk); #1;
        ctrl_req.start = 1'b1;
        ctrl_req.config_data = 16'h00AA;
        @(posedge clk); #1;
        ctrl_req.start = 1'b0;
        exp_cfg = 16'h00AA;
        run_err = 8'h00;
        reached = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ctrl_resp.state == LOAD_INPUT) begin
                reached = 1;
                break;
            end
        end
        chk("reach_load_input", reached, 1);
        @(negedge clk);
        chk("mid_re_active", mem_req.re, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_cfg = '0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
